// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame engine: frame states, line-select codes, idle level.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/config/line bundle between the TX register block and the frame engine.
// send_break exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  busy;
`ifdef UART_TX_BREAK_EN
    logic                  send_break;

    modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, send_break,
                    input  TX_OUT, busy);
    modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, send_break,
                    output TX_OUT, busy);
`else
    modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
                    input  TX_OUT, busy);
    modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
                    output TX_OUT, busy);
`endif
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Purpose: parity bit of a payload word, even (PAR_TYP=0) or odd (PAR_TYP=1).
// Latency: combinational.
// Backpressure: none.
module uart_tx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  PAR_TYP,
    output logic                  par_bit
);
    assign par_bit = (^data) ^ PAR_TYP;
endmodule

// File: rtl/uart_tx_frame.sv
// Purpose: serialises one payload word per accept into a UART frame (start, data LSB first, opt parity, 1/2 stop).
// Latency: TX_OUT falls and busy rises on the edge that samples Data_Valid; each line bit lasts CLKS_PER_BIT cycles.
// Backpressure: Data_Valid is dropped (not queued) while busy=1; UART_TX_BREAK_EN adds send_break line hold.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_frame_if.slave  bus
);
    import uart_tx_pkg::*;

    localparam int CW = $clog2((CLKS_PER_BIT > 2) ? CLKS_PER_BIT : 2);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q, stop2_q;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_done, load, brk_req, brk, par_bit;
    logic [1:0]            line_sel;

`ifdef UART_TX_BREAK_EN
    assign brk_req = bus.send_break;
`else
    assign brk_req = 1'b0;
`endif

    assign bit_done = (cnt_q == CNT_LAST);
    // Break only takes the line in IDLE, so a running frame always completes.
    assign brk      = (state_q == S_IDLE) && brk_req;
    assign load     = (state_q == S_IDLE) && !brk_req && bus.Data_Valid;

    uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (data_q),
        .PAR_TYP (par_typ_q),
        .par_bit (par_bit)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = bit_done ? '0 : cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (load) state_d = S_START;
            end
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA: if (bit_done) begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_PARITY: if (bit_done) state_d = S_STOP;
            // idx counts stop bits here: a second one only when STOP2 was latched.
            S_STOP: if (bit_done) begin
                if (stop2_q && idx_q == '0) begin
                    idx_d = IW'(1);
                end else begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            S_START:  line_sel = SEL_START;
            S_DATA:   line_sel = SEL_DATA;
            S_PARITY: line_sel = SEL_PAR;
            default:  line_sel = SEL_STOP;
        endcase
        case (line_sel)
            SEL_START: tx_d = 1'b0;
            SEL_DATA:  tx_d = data_q[idx_d];
            SEL_PAR:   tx_d = par_bit;
            default:   tx_d = IDLE_LEVEL;
        endcase
        if (brk) tx_d = 1'b0;
        busy_d = (state_d != S_IDLE) || brk;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load) begin
                data_q    <= bus.P_DATA;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                stop2_q   <= bus.STOP2;
            end
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;

endmodule
